// File: rtl/ahbslv_wbmas_bridge.sv
// AHB-Lite slave to Wishbone classic master bridge.
// Each single AHB transfer becomes one Wishbone cycle.
module ahbslv_wbmas_bridge #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DWIDTH-1:0] hrdata,
  output logic [AWIDTH-1:0] wb_adr_o,
  output logic [DWIDTH-1:0] wb_dat_o,
  input  logic [DWIDTH-1:0] wb_dat_i,
  output logic [3:0]        wb_sel_o,
  output logic              wb_we_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_ERR1,
    S_ERR2
  } state_e;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] adr_q, adr_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic       valid;
  logic       accept;
  logic       legal;
  logic       timeout;
  logic [3:0] sel_req;
  logic       unused_ok;

  assign unused_ok = ^{hburst, htrans[0]};

  assign valid = hsel & htrans[1] & hready;

  // Only IDLE/DONE/ERR2 present hreadyout=1, so only they can see an address phase.
  assign accept = valid & ((state_q == S_IDLE) |
                           (state_q == S_DONE) |
                           (state_q == S_ERR2));

  assign timeout = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    sel_req = 4'b1111;
    legal   = 1'b1;
    unique case (1'b1)
      hsize == 3'd0: sel_req = 4'b0001 << haddr[1:0];
      hsize == 3'd1: begin
        sel_req = haddr[1] ? 4'b1100 : 4'b0011;
        legal   = ~haddr[0];
      end
      hsize == 3'd2: legal = (haddr[1:0] == 2'b00);
      default:       legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    hreadyout = 1'b1;
    hresp     = 2'b00;
    wb_cyc_o  = 1'b0;
    if (accept) begin
      adr_d = {haddr[AWIDTH-1:2], 2'b00};
      we_d  = hwrite;
      sel_d = sel_req;
    end
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (state_q == S_ERR2) hresp = 2'b01;
        if (accept) begin
          state_d = legal ? S_WAIT : S_ERR1;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        wb_cyc_o  = 1'b1;
        if (wb_err_i) begin
          state_d = S_ERR1;
        end else if (wb_ack_i) begin
          state_d = S_DONE;
          if (!we_q) rdata_d = wb_dat_i;
        end else if (timeout) begin
          state_d = S_ERR1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 2'b01;
        state_d   = S_ERR2;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_stb_o = wb_cyc_o;
  assign wb_adr_o = adr_q;
  assign wb_we_o  = we_q;
  assign wb_sel_o = sel_q;
  assign wb_dat_o = hwdata;
  assign hrdata   = rdata_q;

endmodule

// File: tb/tb_ahbslv_wbmas_bridge.sv
// Bench for ahbslv_wbmas_bridge: directed and randomized
// AHB transfers against a transfer-level reference model.
module tb_ahbslv_wbmas_bridge;

  localparam int TO = 16;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = '0;
  logic [2:0]  hburst = '0;
  logic [31:0] hwdata = '0;
  logic        hready = 1'b1;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  ahbslv_wbmas_bridge #(
    .AWIDTH(32),
    .DWIDTH(32),
    .TIMEOUT(TO)
  ) dut (
    .hclk(hclk),
    .hresetn(hresetn),
    .hsel(hsel),
    .haddr(haddr),
    .htrans(htrans),
    .hwrite(hwrite),
    .hsize(hsize),
    .hburst(hburst),
    .hwdata(hwdata),
    .hready(hready),
    .hreadyout(hreadyout),
    .hresp(hresp),
    .hrdata(hrdata),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o),
    .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;

  logic [31:0] rdata_m = '0;

  int          o_wait, o_cyc, o_first, o_errlow, o_nostb;
  bit          o_bound;
  logic [31:0] o_adr, o_dat, o_rdata;
  logic [3:0]  o_sel;
  logic        o_we;
  logic [1:0]  o_resp;

  function automatic bit legal_of(input logic [31:0] a,
                                  input logic [2:0] sz);
    if (sz == 3'd0) return 1'b1;
    if (sz == 3'd1) return a[0] == 1'b0;
    if (sz == 3'd2) return a[1:0] == 2'b00;
    return 1'b0;
  endfunction

  function automatic logic [3:0] lanes_of(input logic [31:0] a,
                                          input logic [2:0] sz);
    logic [3:0] s;
    s = 4'b0000;
    if (sz == 3'd0) s[a[1:0]] = 1'b1;
    else if (sz == 3'd1) begin
      s[{a[1], 1'b0}] = 1'b1;
      s[{a[1], 1'b1}] = 1'b1;
    end else s = 4'b1111;
    return s;
  endfunction

  task automatic go_idle(input int n);
    hsel   = 1'b0;
    htrans = 2'b00;
    repeat (n) @(negedge hclk);
  endtask

  // Drives one AHB transfer and plays a Wishbone slave that acks
  // (with optional err) on cycle ack_at of cyc; ack_at=0 never acks.
  task automatic do_xfer(input logic [31:0] a, input logic [2:0] sz,
                         input logic wr, input logic [31:0] wd,
                         input logic [31:0] rd, input int ack_at,
                         input bit err);
    bit fin;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    hburst = 3'($urandom);
    hready = 1'b1;
    @(posedge hclk);
    #1;
    hsel     = 1'($urandom);
    htrans   = {1'b0, 1'($urandom)};
    haddr    = $urandom;
    hwrite   = 1'($urandom);
    hsize    = 3'($urandom);
    hready   = 1'($urandom);
    hwdata   = wd;
    wb_dat_i = rd;
    o_wait = 0; o_cyc = 0; o_first = 0; o_errlow = 0; o_nostb = 0;
    o_adr = '0; o_dat = '0; o_sel = '0; o_we = 1'b0;
    o_resp = 2'b11; o_rdata = '0;
    fin = 1'b0;
    for (int k = 1; k <= 100 && !fin; k++) begin
      @(negedge hclk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (wb_cyc_o) begin
        if (o_cyc == 0) begin
          o_first = k;
          o_adr   = wb_adr_o;
          o_sel   = wb_sel_o;
          o_we    = wb_we_o;
          o_dat   = wb_dat_o;
        end
        if (!wb_stb_o) o_nostb++;
        o_cyc++;
        if (o_cyc == ack_at) begin
          wb_ack_i = 1'b1;
          wb_err_i = err;
        end
      end
      if (!hreadyout) begin
        o_wait++;
        if (hresp == 2'b01) o_errlow++;
      end else begin
        fin     = 1'b1;
        o_resp  = hresp;
        o_rdata = hrdata;
      end
    end
    o_bound = !fin;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      hsel = 1'($urandom); htrans = 2'($urandom); haddr = $urandom;
      hwrite = 1'($urandom); hsize = 3'($urandom); hready = 1'($urandom);
      hwdata = $urandom; wb_dat_i = $urandom;
      wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom);
      @(negedge hclk);
      checks++;
      if ({hreadyout, hresp, hrdata, wb_cyc_o, wb_stb_o, wb_we_o,
           wb_sel_o, wb_adr_o} !== {1'b1, 2'b00, 32'h0, 3'b000, 4'h0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state: rdy=%b resp=%b rdata=%h cyc=%b stb=%b we=%b sel=%b adr=%h required rdy=1 rest 0",
                 hreadyout, hresp, hrdata, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o);
      end
    end
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1;
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    hresetn = 1'b1;
    @(negedge hclk);
  endtask

  task automatic test_idle_busy;
    for (int i = 0; i < 6; i++) begin
      hsel   = (i < 2) ? 1'b1 : (i < 4 ? 1'b0 : 1'b1);
      htrans = (i < 2) ? 2'(i) : 2'b10;
      hready = (i < 4) ? 1'b1 : 1'b0;
      haddr = $urandom; hsize = 3'($urandom);
      wb_ack_i = 1'b1; wb_err_i = 1'(i & 1); wb_dat_i = $urandom;
      @(negedge hclk);
      checks++;
      if ({hreadyout, hresp, wb_cyc_o, hrdata} !== {1'b1, 2'b00, 1'b0, rdata_m}) begin
        errors++;
        $display("FAIL idle_okay[%0d]: rdy=%b resp=%b cyc=%b rdata=%h required 1 00 0 %h",
                 i, hreadyout, hresp, wb_cyc_o, hrdata, rdata_m);
      end
    end
    wb_ack_i = 1'b0; wb_err_i = 1'b0; hready = 1'b1;
    go_idle(1);
  endtask

  task automatic test_word_write;
    do_xfer(32'h1000_0004, 3'd2, 1'b1, 32'hDEAD_BEEF, 32'h0, 3, 1'b0);
    checks++;
    if ({o_adr, o_sel, o_we, o_dat} !== {32'h1000_0004, 4'hF, 1'b1, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL word_write_bus: adr=%h sel=%b we=%b dat=%h required 10000004 1111 1 deadbeef",
               o_adr, o_sel, o_we, o_dat);
    end
    checks++;
    if ({o_wait, o_cyc, o_resp} !== {32'd3, 32'd3, 2'b00}) begin
      errors++;
      $display("FAIL word_write_timing: wait=%0d cyc=%0d resp=%b required 3 3 00",
               o_wait, o_cyc, o_resp);
    end
    go_idle(2);
  endtask

  task automatic test_back_to_back;
    do_xfer(32'h2000_0003, 3'd0, 1'b0, 32'h0, 32'hA1B2_C3D4, 1, 1'b0);
    rdata_m = 32'hA1B2_C3D4;
    checks++;
    if ({o_sel, o_adr, o_rdata, o_wait, o_resp} !==
        {4'b1000, 32'h2000_0000, 32'hA1B2_C3D4, 32'd1, 2'b00}) begin
      errors++;
      $display("FAIL byte_read: sel=%b adr=%h rdata=%h wait=%0d resp=%b required 1000 20000000 a1b2c3d4 1 00",
               o_sel, o_adr, o_rdata, o_wait, o_resp);
    end
    do_xfer(32'h2000_0010, 3'd2, 1'b1, 32'h55AA_0FF0, 32'h1234_5678, 2, 1'b0);
    checks++;
    if ({o_first, o_wait, o_we, o_adr, o_rdata} !==
        {32'd1, 32'd2, 1'b1, 32'h2000_0010, rdata_m}) begin
      errors++;
      $display("FAIL back_to_back: first=%0d wait=%0d we=%b adr=%h rdata=%h required 1 2 1 20000010 %h",
               o_first, o_wait, o_we, o_adr, o_rdata, rdata_m);
    end
    go_idle(2);
  endtask

  task automatic test_wb_error;
    do_xfer(32'h4000_0008, 3'd2, 1'b0, 32'h0, 32'hFFFF_0000, 2, 1'b1);
    checks++;
    if ({o_cyc, o_wait, o_errlow, o_resp, o_rdata} !==
        {32'd2, 32'd3, 32'd1, 2'b01, rdata_m}) begin
      errors++;
      $display("FAIL wb_error: cyc=%0d wait=%0d errlow=%0d resp=%b rdata=%h required 2 3 1 01 %h",
               o_cyc, o_wait, o_errlow, o_resp, o_rdata, rdata_m);
    end
    go_idle(1);
    checks++;
    if ({hreadyout, hresp, wb_cyc_o} !== {1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL err_to_idle: rdy=%b resp=%b cyc=%b required 1 00 0",
               hreadyout, hresp, wb_cyc_o);
    end
    go_idle(1);
  endtask

  task automatic test_timeout;
    do_xfer(32'h5000_0000, 3'd2, 1'b1, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    checks++;
    if ({o_cyc, o_nostb, o_wait, o_errlow, o_resp} !==
        {TO, 32'd0, TO + 1, 32'd1, 2'b01}) begin
      errors++;
      $display("FAIL timeout: cyc=%0d nostb=%0d wait=%0d errlow=%0d resp=%b required %0d 0 %0d 1 01",
               o_cyc, o_nostb, o_wait, o_errlow, o_resp, TO, TO + 1);
    end
    go_idle(1);
    checks++;
    if ({hreadyout, hresp, wb_cyc_o} !== {1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL timeout_idle: rdy=%b resp=%b cyc=%b required 1 00 0",
               hreadyout, hresp, wb_cyc_o);
    end
    go_idle(1);
  endtask

  task automatic test_illegal;
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < 3; i++) begin
      a  = (i == 0) ? 32'h3000_0001 : (i == 1 ? 32'h3000_0000 : 32'h3000_0002);
      sz = (i == 0) ? 3'd1 : (i == 1 ? 3'd3 : 3'd2);
      do_xfer(a, sz, 1'(i == 2), 32'h0, 32'h0, 1, 1'b0);
      checks++;
      if ({o_cyc, o_wait, o_errlow, o_resp, o_rdata} !==
          {32'd0, 32'd1, 32'd1, 2'b01, rdata_m}) begin
        errors++;
        $display("FAIL illegal[%0d]: cyc=%0d wait=%0d errlow=%0d resp=%b rdata=%h required 0 1 1 01 %h",
                 i, o_cyc, o_wait, o_errlow, o_resp, o_rdata, rdata_m);
      end
    end
    go_idle(2);
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd;
    logic [2:0]  sz;
    logic        wr;
    int          ack_at, exp_cyc, exp_wait;
    bit          err, legal, tout, bad;
    for (int n = 0; n < 60; n++) begin
      a      = $urandom;
      sz     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                            : 3'($urandom_range(0, 2));
      wr     = 1'($urandom);
      wd     = $urandom;
      rd     = $urandom;
      ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
      err    = ($urandom_range(0, 5) == 0);
      legal  = legal_of(a, sz);
      tout   = legal && (ack_at == 0);
      exp_cyc  = !legal ? 0 : (tout ? TO : ack_at);
      exp_wait = exp_cyc + ((!legal || tout || err) ? 1 : 0);
      if (legal && !tout && !err && !wr) rdata_m = rd;
      do_xfer(a, sz, wr, wd, rd, ack_at, err);
      checks++;
      if ({o_bound, o_cyc, o_wait, o_nostb} !== {1'b0, exp_cyc, exp_wait, 32'd0}) begin
        errors++;
        $display("FAIL rand_timing[%0d]: bound=%b cyc=%0d wait=%0d nostb=%0d required 0 %0d %0d 0",
                 n, o_bound, o_cyc, o_wait, o_nostb, exp_cyc, exp_wait);
      end
      bad = (!legal || tout || err);
      checks++;
      if ({o_resp, o_errlow, o_rdata} !== {bad ? 2'b01 : 2'b00, bad ? 32'd1 : 32'd0, rdata_m}) begin
        errors++;
        $display("FAIL rand_resp[%0d]: resp=%b errlow=%0d rdata=%h required %b %0d %h",
                 n, o_resp, o_errlow, o_rdata, bad ? 2'b01 : 2'b00, bad ? 1 : 0, rdata_m);
      end
      if (legal) begin
        checks++;
        if ({o_first, o_adr, o_sel, o_we, o_dat} !==
            {32'd1, a[31:2], 2'b00, lanes_of(a, sz), wr, wd}) begin
          errors++;
          $display("FAIL rand_bus[%0d]: first=%0d adr=%h sel=%b we=%b dat=%h required 1 %h %b %b %h",
                   n, o_first, o_adr, o_sel, o_we, o_dat,
                   {a[31:2], 2'b00}, lanes_of(a, sz), wr, wd);
        end
      end
      go_idle($urandom_range(0, 2));
    end
    go_idle(1);
  endtask

  task automatic test_reset_mid;
    hsel = 1'b1; htrans = 2'b11; haddr = 32'h6000_0004;
    hwrite = 1'b0; hsize = 3'd2; hready = 1'b1;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk);
    checks++;
    if ({wb_cyc_o, hreadyout} !== 2'b10) begin
      errors++;
      $display("FAIL mid_setup: cyc=%b rdy=%b required 1 0", wb_cyc_o, hreadyout);
    end
    hresetn = 1'b0;
    #1;
    rdata_m = '0;
    checks++;
    if ({wb_cyc_o, wb_stb_o, hreadyout, hresp, hrdata, wb_adr_o, wb_sel_o, wb_we_o} !==
        {1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: cyc=%b stb=%b rdy=%b resp=%b rdata=%h adr=%h sel=%b we=%b required 0 0 1 00 0 0 0 0",
               wb_cyc_o, wb_stb_o, hreadyout, hresp, hrdata, wb_adr_o, wb_sel_o, wb_we_o);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    go_idle(1);
    do_xfer(32'h7000_0002, 3'd1, 1'b0, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
    rdata_m = 32'h0BAD_F00D;
    checks++;
    if ({o_first, o_sel, o_rdata, o_resp} !== {32'd1, 4'b1100, rdata_m, 2'b00}) begin
      errors++;
      $display("FAIL after_reset: first=%0d sel=%b rdata=%h resp=%b required 1 1100 %h 00",
               o_first, o_sel, o_rdata, o_resp, rdata_m);
    end
    go_idle(1);
  endtask

  initial begin
    test_reset;
    test_idle_busy;
    test_word_write;
    test_back_to_back;
    test_wb_error;
    test_timeout;
    test_illegal;
    test_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
